imem_fetch_ctrl: RTL



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/imem_fetch_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its prefetch queue.
package fetch_pkg;

  localparam int INST_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int PC_W       = 10;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue with push/pop/flush, occupancy count and combinational head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wr_entry_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Flush wins over everything; a pop in a flush cycle has nothing left to advance.
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wr_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fills the prefetch queue from a zero-latency
// instruction memory and hands words to decode; redirects flush and may fault.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = PC_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;
  logic              push;
  logic              pop;

  // Handshake: a head word transfers on any rising edge where inst_valid and inst_ready
  // are both high; inst/inst_pc stay stable while inst_valid is high and inst_ready is low.
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        state_d    = RUN;
        fetch_pc_d = redirect_pc;
      end else begin
        state_d = FAULT;
      end
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN: begin
          push = (count != FULL_CNT) | pop;
          if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_BYTES);
        end
        FAULT:   state_d = FAULT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign wr_entry.pc   = PC_W'(fetch_pc_q);
  assign wr_entry.word = imem_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .wr_entry_i (wr_entry),
    .head_o     (head),
    .count_o    (count)
  );

  assign imem_addr = fetch_pc_q;
  assign inst      = head.word;
  assign inst_pc   = ADDR_W'(head.pc);
  assign fault     = (state_q == FAULT);

endmodule
